// File: rtl/auto_player_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : auto_player_pkg
//  Purpose  : Shared encodings for the scripted UART opponent: board square
//             codes, result codes (same numbering as the game side), ASCII
//             framing characters and the move priority table.
//  Revision : 1.0  initial release
// ============================================================================
package auto_player_pkg;

    // Board square encodings
    localparam logic [1:0] c_sq_empty = 2'b00;
    localparam logic [1:0] c_sq_o     = 2'b01;
    localparam logic [1:0] c_sq_x     = 2'b10;

    // Result codes
    localparam logic [1:0] c_res_none = 2'd0;
    localparam logic [1:0] c_res_xwin = 2'd1;   // FPGA wins
    localparam logic [1:0] c_res_owin = 2'd2;   // player wins
    localparam logic [1:0] c_res_draw = 2'd3;

    // ASCII characters the parser cares about
    localparam logic [7:0] c_lf    = 8'h0A;
    localparam logic [7:0] c_cr    = 8'h0D;
    localparam logic [7:0] c_bar   = 8'h7C;
    localparam logic [7:0] c_space = 8'h20;
    localparam logic [7:0] c_ch_o  = 8'h4F;
    localparam logic [7:0] c_ch_x  = 8'h58;
    localparam logic [7:0] c_ch_t  = 8'h54;
    localparam logic [7:0] c_ch_s  = 8'h53;
    localparam logic [7:0] c_ch_g  = 8'h67;
    localparam logic [7:0] c_ch_f  = 8'h46;
    localparam logic [7:0] c_ch_h  = 8'h68;
    localparam logic [7:0] c_ch_0  = 8'h30;

    // Move priority, highest priority in the most significant nibble
    localparam logic [35:0] c_move_prio = {4'd5, 4'd1, 4'd3, 4'd7, 4'd9,
                                           4'd2, 4'd4, 4'd6, 4'd8};

    // First empty square in priority order, 0 when the board is full.
    // Walks from lowest to highest priority so the last hit is the winner.
    function automatic logic [3:0] pick_move(input logic [17:0] board);
        logic [3:0] sel;
        logic [3:0] sq;
        sel = 4'd0;
        for (int i = 0; i < 9; i++) begin
            sq = c_move_prio[4*i +: 4];
            if (board[2*(9 - int'(sq)) +: 2] == c_sq_empty) begin
                sel = sq;
            end
        end
        return sel;
    endfunction

    // Map a cell character to {invalid, square code}
    function automatic logic [2:0] char_to_sq(input logic [7:0] ch);
        logic [2:0] r;
        case (ch)
            c_space: r = {1'b0, c_sq_empty};
            c_ch_o:  r = {1'b0, c_sq_o};
            c_ch_x:  r = {1'b0, c_sq_x};
            default: r = {1'b1, c_sq_empty};
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/auto_player_board_line_parser.sv
`default_nettype none
// ============================================================================
//  Module   : board_line_parser
//  Purpose  : Tracks column/row position in the game's text output, rebuilds
//             the 18-bit board from three valid row lines and recognises the
//             three result strings.
//  Ports    : i_clk, i_reset          clock / sync active-high reset
//             i_rx_stb, i_rx_data     received byte strobe and data
//             o_board_stb, o_board    pulse + board when a third row commits
//             o_result_stb, o_result  pulse + code when a result line is seen
//  Revision : 1.0  initial release
// ============================================================================
module board_line_parser
    import auto_player_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_stb,
    input  logic [7:0]  i_rx_data,
    output logic        o_board_stb,
    output logic [17:0] o_board,
    output logic        o_result_stb,
    output logic [1:0]  o_result
);

    logic [3:0] r_col;
    logic [1:0] r_row;
    logic [5:0] r_rowbuf0;
    logic [5:0] r_rowbuf1;
    logic [5:0] r_line;      // squares captured from the current line
    logic [7:0] r_first;     // first byte of the current line
    logic [1:0] r_bar_ok;    // '|' seen at cols 3 and 7
    logic       r_bad;       // an illegal cell character was seen

    logic [2:0] w_sq;
    logic       w_row_valid;

    assign w_sq        = char_to_sq(i_rx_data);
    assign w_row_valid = (r_col == 4'd11) && (&r_bar_ok) && !r_bad;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_col        <= 4'd0;
            r_row        <= 2'd0;
            r_rowbuf0    <= 6'd0;
            r_rowbuf1    <= 6'd0;
            r_line       <= 6'd0;
            r_first      <= 8'd0;
            r_bar_ok     <= 2'b00;
            r_bad        <= 1'b0;
            o_board      <= 18'd0;
            o_board_stb  <= 1'b0;
            o_result     <= c_res_none;
            o_result_stb <= 1'b0;
        end else begin
            o_board_stb  <= 1'b0;
            o_result_stb <= 1'b0;
            if (i_rx_stb && (i_rx_data != c_cr)) begin
                if (i_rx_data == c_lf) begin
                    if (w_row_valid) begin
                        case (r_row)
                            2'd0: begin
                                r_rowbuf0 <= r_line;
                                r_row     <= 2'd1;
                            end
                            2'd1: begin
                                r_rowbuf1 <= r_line;
                                r_row     <= 2'd2;
                            end
                            default: begin
                                o_board     <= {r_rowbuf0, r_rowbuf1, r_line};
                                o_board_stb <= 1'b1;
                                r_row       <= 2'd0;
                            end
                        endcase
                    end else if ((r_col == 4'd0) && (r_row != 2'd0)) begin
                        // Blank line mid-board: discard the partial board
                        r_row <= 2'd0;
                    end
                    r_col    <= 4'd0;
                    r_line   <= 6'd0;
                    r_first  <= 8'd0;
                    r_bar_ok <= 2'b00;
                    r_bad    <= 1'b0;
                end else begin
                    if (r_col != 4'd15) begin
                        r_col <= r_col + 4'd1;
                    end
                    case (r_col)
                        4'd0: r_first <= i_rx_data;
                        4'd1: begin
                            r_line[5:4] <= w_sq[1:0];
                            r_bad       <= r_bad | w_sq[2];
                        end
                        4'd3: r_bar_ok[0] <= (i_rx_data == c_bar);
                        4'd4: begin
                            if ((r_first == c_ch_t) && (i_rx_data == c_ch_g)) begin
                                o_result     <= c_res_draw;
                                o_result_stb <= 1'b1;
                            end else if ((r_first == c_ch_t) && (i_rx_data == c_ch_f)) begin
                                o_result     <= c_res_xwin;
                                o_result_stb <= 1'b1;
                            end else if ((r_first == c_ch_s) && (i_rx_data == c_ch_h)) begin
                                o_result     <= c_res_owin;
                                o_result_stb <= 1'b1;
                            end
                        end
                        4'd5: begin
                            r_line[3:2] <= w_sq[1:0];
                            r_bad       <= r_bad | w_sq[2];
                        end
                        4'd7: r_bar_ok[1] <= (i_rx_data == c_bar);
                        4'd9: begin
                            r_line[1:0] <= w_sq[1:0];
                            r_bad       <= r_bad | w_sq[2];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/auto_player.sv
`default_nettype none
// ============================================================================
//  Module   : auto_player
//  Purpose  : Scripted far-end opponent for the game's UART link. Parses the
//             printed board, waits for the line to go quiet and answers with
//             a move digit '1'..'9'; a result line cancels a pending move.
//  Ports    : i_clk, i_reset          clock / sync active-high reset
//             i_rx_stb, i_rx_data     byte from the receiver
//             i_tx_busy               transmitter busy
//             o_tx_stb, o_tx_data     one-cycle send strobe and byte
//             o_board, o_board_stb    last complete board and its pulse
//             o_result, o_result_stb  last result code and its pulse
//             o_move                  last move sent
//  Revision : 1.0  initial release
// ============================================================================
module auto_player
    import auto_player_pkg::*;
#(
    parameter logic [23:0] QUIET_CLKS = 24'd20000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_stb,
    input  logic [7:0]  i_rx_data,
    input  logic        i_tx_busy,
    output logic        o_tx_stb,
    output logic [7:0]  o_tx_data,
    output logic [17:0] o_board,
    output logic        o_board_stb,
    output logic [1:0]  o_result,
    output logic        o_result_stb,
    output logic [3:0]  o_move
);

    localparam logic [1:0] c_st_parse = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_pick  = 2'd2;
    localparam logic [1:0] c_st_send  = 2'd3;

    logic [1:0]  r_state;
    logic        r_board_ready;
    logic [23:0] r_quiet;
    logic [3:0]  w_pick;

    board_line_parser u_parser (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_stb     (i_rx_stb),
        .i_rx_data    (i_rx_data),
        .o_board_stb  (o_board_stb),
        .o_board      (o_board),
        .o_result_stb (o_result_stb),
        .o_result     (o_result)
    );

    assign w_pick = pick_move(o_board);

    // Strobe is qualified by busy directly so it can never overlap busy;
    // leaving SEND on the same edge keeps it to a single cycle.
    assign o_tx_stb = (r_state == c_st_send) && !i_tx_busy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= c_st_parse;
            r_board_ready <= 1'b0;
            r_quiet       <= 24'd0;
            o_move        <= 4'd0;
            o_tx_data     <= 8'd0;
        end else begin
            // A result in the same cycle as a board commit takes precedence
            if (o_result_stb) begin
                r_board_ready <= 1'b0;
            end else if (o_board_stb) begin
                r_board_ready <= 1'b1;
            end

            case (r_state)
                c_st_parse: begin
                    if (r_board_ready && !o_result_stb) begin
                        r_quiet <= 24'd0;
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (o_result_stb) begin
                        r_state <= c_st_parse;
                    end else if (i_rx_stb) begin
                        r_quiet <= 24'd0;
                    end else if (r_quiet == QUIET_CLKS - 24'd1) begin
                        r_state <= c_st_pick;
                    end else if (r_quiet != 24'hFF_FFFF) begin
                        r_quiet <= r_quiet + 24'd1;
                    end
                end
                c_st_pick: begin
                    if (w_pick == 4'd0) begin
                        r_board_ready <= 1'b0;
                        r_state       <= c_st_parse;
                    end else begin
                        o_move    <= w_pick;
                        o_tx_data <= c_ch_0 + {4'h0, w_pick};
                        r_state   <= c_st_send;
                    end
                end
                default: begin
                    if (!i_tx_busy) begin
                        r_board_ready <= 1'b0;
                        r_state       <= c_st_parse;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
